pgr_apb_arbiter_32bit: RTL and testbench
========================================

// Module: pgr_apb_arbiter_32bit
// PURPOSE
//  Two-master to one-slave APB arbiter for the 32-bit register bus. Master 0 is the UART-to-APB bridge
//  and master 1 is the local init/config sequencer. Both share the one APB slave port of the PCIe test
//  register bank. The arbiter terminates each master's transfer, replays it to the slave with fresh
//  SETUP/ACCESS phases, and returns the read data. Grants are round-robin. Transfers are never interleaved.
// PARAMETERS
//  AW          16     address width
//  DW          32     data width
//  SW          4      strobe width (DW/8)
//  TIMEOUT_CYC 1024   ACCESS-phase wait limit in cycles; used only with APB_TIMEOUT_EN
// PORTS
//  i_clk        in   1   clock
//  i_rst_n      in   1   asynchronous active-low reset
//  i_m{0,1}_sel, i_m{0,1}_enable, i_m{0,1}_we   in  1      master APB controls
//  i_m{0,1}_addr  in AW  |  i_m{0,1}_wdata  in DW  |  i_m{0,1}_strb  in SW
//  o_m{0,1}_ready out 1  |  o_m{0,1}_rdata  out DW
//  o_s_sel, o_s_enable, o_s_we   out 1   slave APB controls
//  o_s_addr out AW  |  o_s_wdata out DW  |  o_s_strb out SW
//  i_s_ready in 1   |  i_s_rdata in DW
//  o_busy       out  1   high whenever state != IDLE
//  o_grant      out  1   index of the owning master; valid while o_busy
//  o_timeout    out  1   one-cycle pulse on abort (tied 0 without APB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs are 0, state=IDLE, rr_last=1 (so m0 wins the first tie).
//  Request:
//   - req_i = i_mi_sel & i_mi_enable. Only the master ACCESS phase counts; SETUP alone is ignored.
//  FSM:
//   - IDLE  : if any req, pick the winner, latch its addr/wdata/strb/we and o_grant -> SETUP.
//   - SETUP : o_s_sel=1, o_s_enable=0 -> ACCESS.
//   - ACCESS: o_s_sel=1, o_s_enable=1. Stay until i_s_ready=1, then latch i_s_rdata -> RESP.
//   - RESP  : o_m<grant>_ready=1 for exactly one cycle, o_m<grant>_rdata=latched data,
//             o_s_sel=0, o_s_enable=0, rr_last<=grant -> IDLE.
//  Latency:
//   - Zero-wait slave: ready reaches the master in cycle T+3, where T is its first ACCESS cycle seen in IDLE.
//   - Each slave wait state adds 1 cycle.
//  Arbitration:
//   - Both masters requesting in IDLE: the master != rr_last wins.
//   - Single request: that master wins, regardless of rr_last.
//   - The losing master stays in ACCESS with ready=0 (APB wait states) and is served next.
//   - No request is ever dropped.
//  No double capture:
//   - After RESP the master has dropped enable, so the next IDLE does not re-capture the same transfer.
//   - Back-to-back requests from one master are served back-to-back when the other master is idle.
//  Outputs:
//   - o_mi_rdata holds its last value outside RESP.
//   - The non-granted master's ready stays 0.
//   - Slave-side outputs come straight from registers; no combinational path master->slave.
//  Writes: o_s_wdata/o_s_strb/o_s_we are passed through unchanged from the latch. Strobe is not modified.
//  Reset mid-transfer: async return to IDLE with all outputs 0. The interrupted transfer is lost;
//   the masters are reset from the same source.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entering ACCESS and counts each cycle with i_s_ready=0.
//   - When it reaches TIMEOUT_CYC-1: go to RESP with rdata=32'hDEAD_BEEF, pulse o_timeout,
//     and drop o_s_sel/o_s_enable the following cycle.
//  APB_TIMEOUT_EN undefined:
//   - ACCESS waits indefinitely, no counter is built, o_timeout=0.
// STRUCTURE
//  Shared package pgr_apb_arb_pkg:
//   - state encoding IDLE/SETUP/ACCESS/RESP (2-bit)
//   - TIMEOUT_RDATA = 32'hDEAD_BEEF
//   - counter width constant
//  Sub-module pgr_apb_rr_arb2:
//   - combinational 2-way round-robin winner from req[1:0] and rr_last
//   - output: gnt index and gnt_vld
// TESTING
//  1. m0 writes 0x0010<-0x12345678, strb=4'hF, zero-wait slave -> slave sees SETUP then ACCESS with
//     same addr/data; o_m0_ready at T+3; o_m1_ready stays 0.
//  2. m1 reads 0x0020; slave returns 0xA5A5_0001 after 2 wait states -> o_m1_rdata=0xA5A5_0001 with
//     o_m1_ready at T+5.
//  3. m0 and m1 raise ACCESS in the same cycle, 3 rounds -> grant order 0,1,0,1,0,1; every transfer completes.
//  4. m0 issues 4 back-to-back writes while m1 idle -> 4 slave transfers in order, addrs 0x0,0x4,0x8,0xC,
//     none duplicated.
//  5. APB_TIMEOUT_EN, TIMEOUT_CYC=8, slave never ready -> o_timeout pulses once; o_m0_ready with
//     rdata=0xDEADBEEF; arbiter returns to IDLE.
//  6. Assert i_rst_n low during ACCESS -> all outputs 0 immediately; state IDLE; a new request afterwards
//     is served normally.

Source files
------------

// File: rtl/pgr_apb_arb_pkg.sv
// Shared types and constants for the two-master APB arbiter (pgr_apb_arbiter_32bit).
// The timeout constants are used only when APB_TIMEOUT_EN is defined.
package pgr_apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam int          TMO_CNT_W     = 16;

    // A tie goes to the master that was not served last; otherwise the lone requester wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic rr_last);
        if (req == 2'b11) begin
            return ~rr_last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/pgr_apb_rr_arb2.sv
// Combinational two-way round-robin picker: winner index plus a valid flag.
module pgr_apb_rr_arb2
    import pgr_apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       gnt,
    output logic       gnt_vld
);

    assign gnt     = rr_pick(req, rr_last);
    assign gnt_vld = |req;

endmodule

// File: rtl/pgr_apb_arbiter_32bit.sv
// Two-master to one-slave APB arbiter: terminates each master transfer and replays it to the slave.
// Optional ACCESS-phase timeout is enabled with the APB_TIMEOUT_EN macro.
module pgr_apb_arbiter_32bit
    import pgr_apb_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int SW          = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_m0_sel,
    input  logic          i_m0_enable,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    input  logic [SW-1:0] i_m0_strb,
    output logic          o_m0_ready,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_sel,
    input  logic          i_m1_enable,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    input  logic [SW-1:0] i_m1_strb,
    output logic          o_m1_ready,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_s_sel,
    output logic          o_s_enable,
    output logic          o_s_we,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_wdata,
    output logic [SW-1:0] o_s_strb,
    input  logic          i_s_ready,
    input  logic [DW-1:0] i_s_rdata,
    output logic          o_busy,
    output logic          o_grant,
    output logic          o_timeout
);

    arb_state_e    state_reg;
    logic          rr_last_reg;
    logic          grant_reg;
    logic          busy_reg;
    logic          s_sel_reg;
    logic          s_enable_reg;
    logic          s_we_reg;
    logic [AW-1:0] s_addr_reg;
    logic [DW-1:0] s_wdata_reg;
    logic [SW-1:0] s_strb_reg;
    logic [1:0]    m_ready_reg;
    logic [DW-1:0] m0_rdata_reg;
    logic [DW-1:0] m1_rdata_reg;

    logic [1:0]    req;
    logic          arb_gnt;
    logic          arb_gnt_vld;
    logic          resp_go;
    logic [DW-1:0] resp_data;

    // Only the master ACCESS phase is a request; SETUP alone is ignored.
    assign req = {i_m1_sel & i_m1_enable, i_m0_sel & i_m0_enable};

    pgr_apb_rr_arb2 u_rr_arb2 (
        .req     (req),
        .rr_last (rr_last_reg),
        .gnt     (arb_gnt),
        .gnt_vld (arb_gnt_vld)
    );

`ifdef APB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt_reg;
    logic                 timeout_reg;
    logic                 tmo_hit;

    always_comb begin
        resp_go   = 1'b0;
        resp_data = i_s_rdata;
        tmo_hit   = 1'b0;
        if (state_reg == ST_ACCESS) begin
            if (i_s_ready) begin
                resp_go = 1'b1;
            end else if (tmo_cnt_reg == TMO_CNT_W'(TIMEOUT_CYC - 1)) begin
                resp_go   = 1'b1;
                tmo_hit   = 1'b1;
                resp_data = DW'(TIMEOUT_RDATA);
            end
        end
    end

    assign o_timeout = timeout_reg;
`else
    logic unused_timeout_cyc;

    always_comb begin
        resp_go   = (state_reg == ST_ACCESS) && i_s_ready;
        resp_data = i_s_rdata;
    end

    assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
    assign o_timeout          = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            rr_last_reg  <= 1'b1;
            grant_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            s_sel_reg    <= 1'b0;
            s_enable_reg <= 1'b0;
            s_we_reg     <= 1'b0;
            s_addr_reg   <= '0;
            s_wdata_reg  <= '0;
            s_strb_reg   <= '0;
            m_ready_reg  <= '0;
            m0_rdata_reg <= '0;
            m1_rdata_reg <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
            timeout_reg  <= 1'b0;
`endif
        end else begin
            m_ready_reg <= '0;
`ifdef APB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (arb_gnt_vld) begin
                        grant_reg   <= arb_gnt;
                        s_we_reg    <= arb_gnt ? i_m1_we    : i_m0_we;
                        s_addr_reg  <= arb_gnt ? i_m1_addr  : i_m0_addr;
                        s_wdata_reg <= arb_gnt ? i_m1_wdata : i_m0_wdata;
                        s_strb_reg  <= arb_gnt ? i_m1_strb  : i_m0_strb;
                        s_sel_reg   <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    s_enable_reg <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_reg  <= '0;
`endif
                    state_reg    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (resp_go) begin
                        // Ready and read data are registered so both land in the RESP cycle.
                        s_sel_reg              <= 1'b0;
                        s_enable_reg           <= 1'b0;
                        m_ready_reg[grant_reg] <= 1'b1;
                        if (grant_reg) begin
                            m1_rdata_reg <= resp_data;
                        end else begin
                            m0_rdata_reg <= resp_data;
                        end
`ifdef APB_TIMEOUT_EN
                        timeout_reg <= tmo_hit;
`endif
                        state_reg <= ST_RESP;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    busy_reg    <= 1'b0;
                    rr_last_reg <= grant_reg;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_m0_ready = m_ready_reg[0];
    assign o_m1_ready = m_ready_reg[1];
    assign o_m0_rdata = m0_rdata_reg;
    assign o_m1_rdata = m1_rdata_reg;
    assign o_s_sel    = s_sel_reg;
    assign o_s_enable = s_enable_reg;
    assign o_s_we     = s_we_reg;
    assign o_s_addr   = s_addr_reg;
    assign o_s_wdata  = s_wdata_reg;
    assign o_s_strb   = s_strb_reg;
    assign o_busy     = busy_reg;
    assign o_grant    = grant_reg;

endmodule

// File: tb/tb_pgr_apb_arbiter_32bit.sv
// Scoreboard bench for pgr_apb_arbiter_32bit: master BFMs push expected slave transfers,
// a slave model pops and compares them; read data flows back through per-master queues.
module tb_pgr_apb_arbiter_32bit;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    localparam int NEVER = 1000000;

    logic        clk;
    logic        rst_n;
    logic        m_sel   [2];
    logic        m_en    [2];
    logic        m_we    [2];
    logic [15:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_strb  [2];
    logic        m_rdy   [2];
    logic [31:0] m_rd    [2];
    logic        o_m0_ready, o_m1_ready;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_s_sel, o_s_enable, o_s_we;
    logic [15:0] o_s_addr;
    logic [31:0] o_s_wdata;
    logic [3:0]  o_s_strb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        o_busy, o_grant, o_timeout;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          slave_mode = 0;
    bit          use_fixed_rd = 0;
    logic [31:0] fixed_rd = '0;
    bit          exp_timeout = 0;
    int          tmo_pulses = 0;
    int          slave_xfers = 0;
    int          issued = 0;
    xfer_t       exp_q [2][$];
    logic [31:0] exp_rd [2][$];
    logic        grant_log [$];
    logic [15:0] addr_log [$];

    pgr_apb_arbiter_32bit #(
        .AW(16), .DW(32), .SW(4), .TIMEOUT_CYC(8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_m0_sel    (m_sel[0]),
        .i_m0_enable (m_en[0]),
        .i_m0_we     (m_we[0]),
        .i_m0_addr   (m_addr[0]),
        .i_m0_wdata  (m_wdata[0]),
        .i_m0_strb   (m_strb[0]),
        .o_m0_ready  (o_m0_ready),
        .o_m0_rdata  (o_m0_rdata),
        .i_m1_sel    (m_sel[1]),
        .i_m1_enable (m_en[1]),
        .i_m1_we     (m_we[1]),
        .i_m1_addr   (m_addr[1]),
        .i_m1_wdata  (m_wdata[1]),
        .i_m1_strb   (m_strb[1]),
        .o_m1_ready  (o_m1_ready),
        .o_m1_rdata  (o_m1_rdata),
        .o_s_sel     (o_s_sel),
        .o_s_enable  (o_s_enable),
        .o_s_we      (o_s_we),
        .o_s_addr    (o_s_addr),
        .o_s_wdata   (o_s_wdata),
        .o_s_strb    (o_s_strb),
        .i_s_ready   (s_ready),
        .i_s_rdata   (s_rdata),
        .o_busy      (o_busy),
        .o_grant     (o_grant),
        .o_timeout   (o_timeout)
    );

    assign m_rdy[0] = o_m0_ready;
    assign m_rdy[1] = o_m1_ready;
    assign m_rd[0]  = o_m0_rdata;
    assign m_rd[1]  = o_m1_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete APB transfer from master m; lat is cycles from first ACCESS cycle to ready.
    task automatic apb_xfer(input int m, input logic [15:0] a, input logic we,
                            input logic [31:0] wd, input logic [3:0] st, output int lat);
        xfer_t       x;
        logic [31:0] rd;
        int          t0;
        bit          got;
        x.addr = a; x.we = we; x.wdata = wd; x.strb = st;
        exp_q[m].push_back(x);
        @(posedge clk); #1;
        m_sel[m] = 1'b1; m_en[m] = 1'b0; m_we[m] = we;
        m_addr[m] = a; m_wdata[m] = wd; m_strb[m] = st;
        @(posedge clk); #1;
        m_en[m] = 1'b1;
        t0 = cyc;
        got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (m_rdy[m]) got = 1;
        end
        lat = cyc - t0;
        rd = m_rd[m];
        if (!got) begin
            chk("ready_wait_expired", 64'(m), 64'(m + 16));
            lat = -1;
        end else if (!we) begin
            if (exp_rd[m].size() == 0) chk("rdata_no_expectation", 64'(rd), 64'(~rd));
            else chk($sformatf("m%0d_rdata", m), 64'(rd), 64'(exp_rd[m].pop_front()));
        end
        @(posedge clk); #1;
        m_sel[m] = 1'b0; m_en[m] = 1'b0;
        @(negedge clk);
        if (got) begin
            chk($sformatf("m%0d_rdata_hold", m), 64'(m_rd[m]), 64'(rd));
            chk($sformatf("m%0d_ready_one_cycle", m), 64'(m_rdy[m]), 64'd0);
        end
    endtask

    task automatic rand_master(input int m, input int n);
        int lat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issued++;
            apb_xfer(m, 16'($urandom), 1'($urandom_range(0, 1)), $urandom,
                     4'($urandom_range(1, 15)), lat);
        end
    endtask

    // Slave model: detects each new ACCESS, checks it against the scoreboard, inserts wait states.
    task automatic slave_loop();
        bit    in_xfer = 0;
        bit    prev_setup = 0;
        int    waits = 0;
        logic  g = 1'b0;
        xfer_t x;
        forever begin
            @(posedge clk); #1;
            s_ready = 1'b0;
            if (!rst_n) begin
                in_xfer = 0; prev_setup = 0;
                continue;
            end
            if (in_xfer && !(o_s_sel && o_s_enable)) in_xfer = 0;
            if (!in_xfer && o_s_sel && o_s_enable) begin
                g = o_grant;
                slave_xfers++;
                grant_log.push_back(g);
                addr_log.push_back(o_s_addr);
                chk("setup_before_access", 64'(prev_setup), 64'd1);
                if (exp_q[g].size() == 0) begin
                    chk("unexpected_slave_xfer", 64'(o_s_addr), 64'hFFFF_FFFF);
                end else begin
                    x = exp_q[g].pop_front();
                    chk("slave_xfer", {11'd0, o_s_addr, o_s_we, o_s_wdata, o_s_strb},
                        {11'd0, x.addr, x.we, x.wdata, x.strb});
                end
                waits = (slave_mode < 0) ? int'($urandom_range(0, 3)) : slave_mode;
                in_xfer = 1;
            end
            if (in_xfer) begin
                if (waits == 0) begin
                    s_ready = 1'b1;
                    s_rdata = use_fixed_rd ? fixed_rd : $urandom;
                    if (!o_s_we) exp_rd[g].push_back(s_rdata);
                    in_xfer = 0;
                end else begin
                    waits--;
                end
            end
            prev_setup = o_s_sel && !o_s_enable;
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst_n && o_timeout) tmo_pulses++;
            if (rst_n && (o_m0_ready || o_m1_ready)) begin
                chk("single_ready", 64'(o_m0_ready & o_m1_ready), 64'd0);
                chk("grant_matches_ready", 64'(o_grant), 64'(o_m1_ready));
                chk("busy_in_resp", 64'(o_busy), 64'd1);
                chk("timeout_flag", 64'(o_timeout), 64'(exp_timeout));
                chk("slave_idle_in_resp", {62'd0, o_s_sel, o_s_enable}, 64'd0);
            end
        end
    endtask

    initial begin
        int lat, lat0, lat1, base;
        rst_n = 1'b0;
        s_ready = 1'b0;
        s_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            m_sel[m] = 0; m_en[m] = 0; m_we[m] = 0;
            m_addr[m] = '0; m_wdata[m] = '0; m_strb[m] = '0;
        end
        fork
            slave_loop();
            monitor_loop();
            begin
                #500000;
                $display("FAIL watchdog actual=running required=finished");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {50'd0, o_m0_ready, o_m1_ready, o_s_sel, o_s_enable, o_s_we,
                           o_busy, o_grant, o_timeout, o_s_strb, 2'd0}, 64'd0);
        chk("reset_rdata", {o_m0_rdata, o_m1_rdata}, 64'd0);
        chk("reset_bus", {16'd0, o_s_addr, o_s_wdata}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write from m0, zero-wait slave.
        slave_mode = 0;
        apb_xfer(0, 16'h0010, 1'b1, 32'h1234_5678, 4'hF, lat);
        chk("t1_latency", 64'(lat), 64'd3);

        // Read from m1 with two slave wait states.
        slave_mode = 2; use_fixed_rd = 1; fixed_rd = 32'hA5A5_0001;
        apb_xfer(1, 16'h0020, 1'b0, 32'h0, 4'h0, lat);
        chk("t2_latency", 64'(lat), 64'd5);
        chk("t2_rdata", 64'(o_m1_rdata), 64'hA5A5_0001);
        use_fixed_rd = 0;

        // Simultaneous requests for three rounds must alternate 0,1.
        slave_mode = -1;
        grant_log.delete();
        for (int r = 0; r < 3; r++) begin
            fork
                apb_xfer(0, 16'($urandom), 1'b0, 32'h0, 4'h0, lat0);
                apb_xfer(1, 16'($urandom), 1'b1, $urandom, 4'h3, lat1);
            join
        end
        chk("t3_grant_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("t3_grant_%0d", i), 64'(grant_log[i]), 64'(i % 2));

        // Back-to-back writes from m0 alone.
        base = slave_xfers;
        addr_log.delete();
        for (int i = 0; i < 4; i++)
            apb_xfer(0, 16'(i * 4), 1'b1, $urandom, 4'hF, lat);
        chk("t4_xfer_count", 64'(slave_xfers - base), 64'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk($sformatf("t4_addr_%0d", i), 64'(addr_log[i]), 64'(i * 4));

        // Random traffic from both masters.
        base = slave_xfers;
        issued = 0;
        fork
            rand_master(0, 15);
            rand_master(1, 15);
        join
        chk("rand_xfer_count", 64'(slave_xfers - base), 64'(issued));

`ifdef APB_TIMEOUT_EN
        slave_mode = NEVER;
        tmo_pulses = 0;
        exp_rd[0].push_back(32'hDEAD_BEEF);
        exp_timeout = 1;
        apb_xfer(0, 16'h0040, 1'b0, 32'h0, 4'h0, lat);
        exp_timeout = 0;
        chk("t5_timeout_pulses", 64'(tmo_pulses), 64'd1);
        chk("t5_back_to_idle", 64'(o_busy), 64'd0);
`endif

        // Reset asserted while the slave is in ACCESS.
        slave_mode = NEVER;
        begin
            xfer_t x;
            bit    seen;
            x.addr = 16'h0abc; x.we = 1'b1; x.wdata = 32'hCAFE_F00D; x.strb = 4'h5;
            exp_q[0].push_back(x);
            @(posedge clk); #1;
            m_sel[0] = 1; m_we[0] = 1; m_addr[0] = x.addr; m_wdata[0] = x.wdata; m_strb[0] = x.strb;
            @(posedge clk); #1;
            m_en[0] = 1;
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (o_s_enable) seen = 1;
            end
            chk("t6_reached_access", 64'(seen), 64'd1);
            #2 rst_n = 1'b0;
            #1;
            chk("t6_async_ctrl", {52'd0, o_m0_ready, o_m1_ready, o_s_sel, o_s_enable, o_s_we,
                                  o_busy, o_grant, o_timeout, o_s_strb}, 64'd0);
            chk("t6_async_data", {16'd0, o_s_addr, o_s_wdata}, 64'd0);
            chk("t6_async_rdata", {o_m0_rdata, o_m1_rdata}, 64'd0);
            m_sel[0] = 0; m_en[0] = 0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        slave_mode = 0;
        apb_xfer(1, 16'h0100, 1'b0, 32'h0, 4'h0, lat);
        chk("t6_after_reset_latency", 64'(lat), 64'd3);

`ifndef APB_TIMEOUT_EN
        chk("no_timeout_pulses", 64'(tmo_pulses), 64'd0);
`endif
        chk("scoreboard_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
